// File: rtl/motor_pwm_if.sv
// Command/pin bundle between the rover sensor logic and the dual H-bridge output stage.
interface motor_pwm_if;
    logic [1:0] motorL;
    logic [1:0] motorR;
    logic [1:0] enableAB;
    logic [1:0] inA;
    logic [1:0] inB;
    logic       pwmA;
    logic       pwmB;
    logic [1:0] at_speed;

    modport master (output motorL, motorR, enableAB,
                    input  inA, inB, pwmA, pwmB, at_speed);
    modport slave  (input  motorL, motorR, enableAB,
                    output inA, inB, pwmA, pwmB, at_speed);
endinterface

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge driver: per-channel soft-start ramp, dead-time on reversal/brake exit,
// shared PWM period counter with period-boundary duty shadowing.
module motor_pwm_channel #(
    parameter int PWM_PERIOD = 1000,
    parameter int MAX_DUTY   = 800,
    parameter int RAMP_STEP  = 50,
    parameter int RAMP_DIV   = 100,
    parameter int DEADTIME   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cmd,
    input  logic [9:0] pcnt_nxt,
    input  logic       wrap,
    output logic [1:0] pins,
    output logic       pwm,
    output logic       at_speed
);
    localparam int PW = $clog2(RAMP_DIV + 1);
    localparam int DW = $clog2(DEADTIME + 1);

    typedef enum logic [2:0] {COAST, DEAD, RAMP, RUN, BRAKE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    dir, dir_nxt;
    logic [9:0]    duty, duty_nxt, shadow, shadow_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [DW-1:0] dead, dead_nxt;
    logic [10:0]   sum;
    logic [1:0]    pins_nxt;
    logic          pwm_nxt;
    logic          drive_now, drive_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COAST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        duty_nxt   = duty;
        presc_nxt  = presc;
        dead_nxt   = dead;
        shadow_nxt = wrap ? duty : shadow;
        sum        = {1'b0, duty} + 11'(RAMP_STEP);
        case (cmd)
            2'b00: begin state_nxt = COAST; duty_nxt = '0; end
            2'b11: begin state_nxt = BRAKE; duty_nxt = '0; end
            default: begin
                case (state)
                    COAST: begin
                        dir_nxt = cmd; state_nxt = RAMP; duty_nxt = '0; presc_nxt = '0;
                    end
                    BRAKE: begin
                        dir_nxt = cmd; state_nxt = DEAD; dead_nxt = DW'(DEADTIME);
                    end
                    DEAD: begin
                        if (cmd != dir) begin
                            dir_nxt = cmd; dead_nxt = DW'(DEADTIME);
                        end else if (dead <= DW'(1)) begin
                            state_nxt = RAMP; duty_nxt = '0; presc_nxt = '0;
                        end else begin
                            dead_nxt = dead - DW'(1);
                        end
                    end
                    RAMP, RUN: begin
                        if (cmd != dir) begin
                            dir_nxt = cmd; state_nxt = DEAD; dead_nxt = DW'(DEADTIME); duty_nxt = '0;
                        end else if (state == RAMP) begin
                            if (presc == PW'(RAMP_DIV - 1)) begin
                                presc_nxt = '0;
                                // 11-bit sum saturates before truncation, so it can't wrap
                                if (sum >= 11'(MAX_DUTY)) begin
                                    duty_nxt  = 10'(MAX_DUTY);
                                    state_nxt = RUN;
                                end else begin
                                    duty_nxt = sum[9:0];
                                end
                            end else begin
                                presc_nxt = presc + PW'(1);
                            end
                        end
                    end
                    default: state_nxt = COAST;
                endcase
            end
        endcase

        drive_now = (state == RAMP) || (state == RUN);
        drive_nxt = (state_nxt == RAMP) || (state_nxt == RUN);
        // dropping out of drive kills the shadow immediately: no stale tail pulse
        if (drive_now && !drive_nxt) shadow_nxt = '0;

        pins_nxt = 2'b00;
        pwm_nxt  = 1'b0;
        if (state_nxt == BRAKE) begin
            pins_nxt = 2'b11;
            pwm_nxt  = 1'b1;
        end else if (drive_nxt) begin
            pins_nxt = dir_nxt;
            pwm_nxt  = (pcnt_nxt < shadow_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir      <= 2'b00;
            duty     <= '0;
            shadow   <= '0;
            presc    <= '0;
            dead     <= '0;
            pins     <= 2'b00;
            pwm      <= 1'b0;
            at_speed <= 1'b0;
        end else begin
            dir      <= dir_nxt;
            duty     <= duty_nxt;
            shadow   <= shadow_nxt;
            presc    <= presc_nxt;
            dead     <= dead_nxt;
            pins     <= pins_nxt;
            pwm      <= pwm_nxt;
            at_speed <= (state_nxt == RUN);
        end
    end
endmodule

module motor_pwm_driver #(
    parameter int PWM_PERIOD = 1000,
    parameter int MAX_DUTY   = 800,
    parameter int RAMP_STEP  = 50,
    parameter int RAMP_DIV   = 100,
    parameter int DEADTIME   = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    motor_pwm_if.slave  drv
);
    logic [9:0]      pcnt, pcnt_nxt;
    logic            wrap;
    logic [1:0][1:0] cmd, pins;
    logic [1:0]      pwm, at_spd;

    assign wrap     = (pcnt == 10'(PWM_PERIOD - 1));
    assign pcnt_nxt = wrap ? 10'd0 : pcnt + 10'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pcnt <= '0;
        else        pcnt <= pcnt_nxt;
    end

    assign cmd[0] = drv.enableAB[0] ? drv.motorL : 2'b00;
    assign cmd[1] = drv.enableAB[1] ? drv.motorR : 2'b00;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        motor_pwm_channel #(
            .PWM_PERIOD(PWM_PERIOD), .MAX_DUTY(MAX_DUTY), .RAMP_STEP(RAMP_STEP),
            .RAMP_DIV(RAMP_DIV), .DEADTIME(DEADTIME)
        ) u_ch (
            .clk(CLK), .rst_n(RST_N), .cmd(cmd[g]), .pcnt_nxt(pcnt_nxt), .wrap(wrap),
            .pins(pins[g]), .pwm(pwm[g]), .at_speed(at_spd[g])
        );
    end

    assign drv.inA      = pins[0];
    assign drv.inB      = pins[1];
    assign drv.pwmA     = pwm[0];
    assign drv.pwmB     = pwm[1];
    assign drv.at_speed = at_spd;
endmodule
